// File: rtl/debounce_strobe.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_strobe
//  Description : Conditions a raw asynchronous level into a debounced data bit
//                (d) and one-cycle load/edge strobes for a downstream D flop.
//                The raw input is synchronized through two flops, then a
//                change must persist for STABLE_COUNT consecutive edges on
//                the synchronized value before it is accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_strobe #(
    parameter int STABLE_COUNT = 4,
    parameter int CNT_W        = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic d,
    output logic enable,
    output logic rise,
    output logic fall,
    output logic busy
);

    // Terminal count: a change is accepted on the edge that finds the
    // counter here while the synchronized input still differs from d.
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(STABLE_COUNT - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    // Reject parameter sets the counter cannot represent.
    generate
        if (STABLE_COUNT < 1 || STABLE_COUNT > ((2 ** CNT_W) - 1)) begin : g_bad_param
            $error("debounce_strobe: STABLE_COUNT out of range for CNT_W");
        end
    endgenerate

    logic             r_s1;
    logic             r_s2;
    logic             r_d;
    logic             r_en;
    logic             r_rise;
    logic             r_fall;
    logic [CNT_W-1:0] r_cnt;

    logic             w_differ;
    logic             w_accept;

    // Qualification is in progress whenever the synchronized level and the
    // accepted level disagree.
    assign w_differ = (r_s2 != r_d);

    // The change has now been seen on STABLE_COUNT consecutive edges.
    assign w_accept = w_differ && (r_cnt == c_CNT_LAST);

    // Two-flop synchronizer: din reaches no other logic directly.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= din;
            r_s2 <= r_s1;
        end
    end

    // Stability counter: cleared while stable or when a glitch aborts, and
    // cleared again on acceptance so strobes are spaced by the full window.
    // It saturates at the terminal count by construction and never wraps.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (!w_differ || w_accept) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
        end
    end

    // Accepted level plus strobes, all valid in the cycle after acceptance.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_d    <= 1'b0;
            r_en   <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_en   <= w_accept;
            r_rise <= w_accept & r_s2;
            r_fall <= w_accept & ~r_s2;
            if (w_accept) begin
                r_d <= r_s2;
            end
        end
    end

    assign d      = r_d;
    assign enable = r_en;
    assign rise   = r_rise;
    assign fall   = r_fall;
    assign busy   = w_differ;

endmodule
`default_nettype wire
